router_port_rx: RTL and testbench

- Downstream consumer for one output port of the 1x3 router (`router_top`).
- Drains the port by driving `read_enb` whenever `vld_out` is high and it has buffer space.
- Re-frames the byte stream into packets: header, payload, parity.
- Checks XOR parity and length, and hands bytes to a sink through a valid/ready interface with SOP/EOP markers. One instance is placed per router output port.

---
 rtl/router_port_rx.sv | 210 +++++++++++++++++++++
 tb/tb_router_port_rx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_port_rx.sv
// router_port_rx: consumer for one router output port.
// Pops the port FIFO, re-frames bytes into header/payload/parity packets,
// checks XOR parity, aborts stalled packets after TIMEOUT idle cycles and
// hands tagged bytes to a sink through a 2-entry skid buffer.
// Optional good/bad packet counters are built when PORT_RX_STATS_EN is defined.
module router_port_rx #(
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 32
`ifdef PORT_RX_STATS_EN
   ,parameter int CNT_W  = 16
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vld_out,
   input  logic [DATA_W-1:0] data_out,
   output logic              read_enb,
   output logic [DATA_W-1:0] pkt_data,
   output logic              pkt_valid,
   input  logic              pkt_ready,
   output logic              pkt_sop,
   output logic              pkt_eop,
   output logic              pkt_err,
   output logic              busy_rx
`ifdef PORT_RX_STATS_EN
   ,output logic [CNT_W-1:0] pkt_count
   ,output logic [CNT_W-1:0] err_count
`endif
);

   localparam int              WD_W    = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
   localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

   // The header is consumed by the capture that happens in IDLE, so the
   // state names the kind of byte expected next.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_PARITY  = 2'd2
   } state_t;

   state_t            r_state, w_state_next;
   logic [5:0]        r_rem, w_rem_next;
   logic [DATA_W-1:0] r_acc, w_acc_next;
   logic [WD_W-1:0]   r_wd, w_wd_next;
   logic              r_inflight;

   logic [1:0][DATA_W-1:0] r_buf_data;
   logic [1:0]             r_buf_sop;
   logic [1:0]             r_buf_eop;
   logic [1:0]             r_buf_err;
   logic                   r_wr_ptr;
   logic                   r_rd_ptr;
   logic [1:0]             r_occ;

   logic              w_full;
   logic              w_pop;
   logic              w_push;
   logic [DATA_W-1:0] w_push_data;
   logic              w_push_sop;
   logic              w_push_eop;
   logic              w_push_err;
   logic              w_abort_fire;
   logic [2:0]        w_commit;

   assign w_full    = (r_occ == 2'd2);
   assign pkt_valid = (r_occ != 2'd0);
   assign w_pop     = pkt_valid & pkt_ready;
   assign pkt_data  = r_buf_data[r_rd_ptr];
   assign pkt_sop   = pkt_valid & r_buf_sop[r_rd_ptr];
   assign pkt_eop   = pkt_valid & r_buf_eop[r_rd_ptr];
   assign pkt_err   = pkt_valid & r_buf_err[r_rd_ptr];
   assign busy_rx   = (r_state != ST_IDLE);

   // Every slot already promised (stored, in flight, or taken by an abort
   // pushed this cycle) counts against the two buffer entries, so a
   // captured byte always finds room.
   assign w_commit = {1'b0, r_occ} + {2'b00, r_inflight} + {2'b00, w_abort_fire};
   assign read_enb = !reset && vld_out && (w_commit < 3'd2);

   // Framing, parity accumulation and watchdog: next state and push request.
   always_comb begin
      w_state_next = r_state;
      w_rem_next   = r_rem;
      w_acc_next   = r_acc;
      w_wd_next    = r_wd;
      w_push       = 1'b0;
      w_push_data  = '0;
      w_push_sop   = 1'b0;
      w_push_eop   = 1'b0;
      w_push_err   = 1'b0;
      w_abort_fire = 1'b0;
      if (r_inflight) begin
         w_push      = 1'b1;
         w_push_data = data_out;
         w_wd_next   = '0;
         case (r_state)
            ST_IDLE: begin
               w_push_sop   = 1'b1;
               w_acc_next   = data_out;
               w_rem_next   = data_out[7:2];
               w_state_next = (data_out[7:2] == 6'd0) ? ST_PARITY : ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
               w_acc_next = r_acc ^ data_out;
               w_rem_next = r_rem - 6'd1;
               if (r_rem == 6'd1) begin
                  w_state_next = ST_PARITY;
               end
            end
            ST_PARITY: begin
               w_push_eop   = 1'b1;
               w_push_err   = (data_out != r_acc);
               w_state_next = ST_IDLE;
            end
            default: begin
               w_state_next = ST_IDLE;
            end
         endcase
      end else if (r_state != ST_IDLE && !w_full) begin
         // A full buffer freezes the watchdog, which also holds a due abort
         // until a slot is free.
         if (r_wd == WD_LAST) begin
            w_abort_fire = 1'b1;
            w_push       = 1'b1;
            w_push_eop   = 1'b1;
            w_push_err   = 1'b1;
            w_wd_next    = '0;
            w_state_next = ST_IDLE;
         end else begin
            w_wd_next = r_wd + WD_ONE;
         end
      end
   end

   // Framing state, accumulator, watchdog and read pipeline registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_rem      <= '0;
         r_acc      <= '0;
         r_wd       <= '0;
         r_inflight <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_rem      <= w_rem_next;
         r_acc      <= w_acc_next;
         r_wd       <= w_wd_next;
         r_inflight <= read_enb;
      end
   end

   // Skid buffer storage: write the tagged byte at the write pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_buf_data <= '0;
         r_buf_sop  <= '0;
         r_buf_eop  <= '0;
         r_buf_err  <= '0;
      end else if (w_push) begin
         r_buf_data[r_wr_ptr] <= w_push_data;
         r_buf_sop[r_wr_ptr]  <= w_push_sop;
         r_buf_eop[r_wr_ptr]  <= w_push_eop;
         r_buf_err[r_wr_ptr]  <= w_push_err;
      end
   end

   // Skid buffer pointers and occupancy; push+pop leaves occupancy alone.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_occ    <= 2'd0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + 2'd1;
            2'b01:   r_occ <= r_occ - 2'd1;
            default: r_occ <= r_occ;
         endcase
      end
   end

`ifdef PORT_RX_STATS_EN
   // Saturating good/bad packet counters, counted as the eop leaves the buffer.
   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_count <= '0;
         err_count <= '0;
      end else if (w_pop && pkt_eop) begin
         if (pkt_err) begin
            if (err_count != {CNT_W{1'b1}}) begin
               err_count <= err_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end else begin
            if (pkt_count != {CNT_W{1'b1}}) begin
               pkt_count <= pkt_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_router_port_rx.sv
// Bench for router_port_rx: router FIFO modelled as a byte queue, expected
// sink stream built per packet from the framing/parity rules, and a single
// negedge process that drives the router/sink side and checks every pop.
module tb_router_port_rx;
   localparam int TIMEOUT = 32;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       vld_out = 1'b0;
   logic [7:0] data_out = 8'h00;
   logic       read_enb;
   logic [7:0] pkt_data;
   logic       pkt_valid;
   logic       pkt_ready = 1'b0;
   logic       pkt_sop;
   logic       pkt_eop;
   logic       pkt_err;
   logic       busy_rx;
`ifdef PORT_RX_STATS_EN
   logic [15:0] pkt_count;
   logic [15:0] err_count;
`endif

   always #5 clk = ~clk;

   router_port_rx #(.DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .vld_out(vld_out), .data_out(data_out),
      .read_enb(read_enb), .pkt_data(pkt_data), .pkt_valid(pkt_valid),
      .pkt_ready(pkt_ready), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop),
      .pkt_err(pkt_err), .busy_rx(busy_rx)
`ifdef PORT_RX_STATS_EN
      , .pkt_count(pkt_count), .err_count(err_count)
`endif
   );

   typedef struct packed {
      logic [7:0] data;
      logic       sop;
      logic       eop;
      logic       err;
      logic       abort;
   } item_t;

   int          errors = 0;
   int          checks = 0;
   int unsigned cyc = 0;
   logic [7:0]  rtr_q[$];
   item_t       exp_q[$];
   int          ready_mode = 0;
   logic        rd_pend = 1'b0;
   logic [7:0]  next_data = 8'h00;
   logic        prev_stall = 1'b0;
   logic [10:0] prev_word = '0;
   int unsigned last_pop_cyc = 0;
   int          cur_len = 0;
   int          last_pkt_len = 0;
   int          last_eop_data = 0;
   int          last_eop_err = 0;
   int          model_good = 0;
   int          model_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Router FIFO, sink handshake and per-cycle output checking.
   always @(negedge clk) begin
      item_t e;
      cyc++;
      data_out = rd_pend ? next_data : 8'($urandom);
      rd_pend  = 1'b0;
      vld_out  = (rtr_q.size() != 0);
      case (ready_mode)
         0:       pkt_ready = 1'b1;
         1:       pkt_ready = ($urandom_range(0, 99) < 60);
         default: pkt_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      endcase
      #1;
      chk("read_without_vld", {31'd0, read_enb & ~vld_out}, 32'd0);
      if (read_enb && rtr_q.size() != 0) begin
         next_data = rtr_q.pop_front();
         rd_pend   = 1'b1;
      end
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", {31'd0, pkt_valid}, 32'd1);
            chk("stall_hold", {21'd0, pkt_data, pkt_sop, pkt_eop, pkt_err}, {21'd0, prev_word});
         end
`ifdef PORT_RX_STATS_EN
         chk("pkt_count", {16'd0, pkt_count}, model_good);
         chk("err_count", {16'd0, err_count}, model_bad);
`endif
         if (pkt_valid && pkt_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_byte: got 0x%0h expected no byte (cycle %0d)", pkt_data, cyc);
            end else begin
               e = exp_q.pop_front();
               chk("data", {24'd0, pkt_data}, {24'd0, e.data});
               chk("tags_sop_eop_err", {29'd0, pkt_sop, pkt_eop, pkt_err}, {29'd0, e.sop, e.eop, e.err});
               if (e.abort) chk("abort_gap", cyc - last_pop_cyc, TIMEOUT);
            end
            last_pop_cyc = cyc;
            cur_len = pkt_sop ? 1 : cur_len + 1;
            if (pkt_eop) begin
               last_pkt_len  = cur_len;
               last_eop_data = pkt_data;
               last_eop_err  = pkt_err;
               if (pkt_err) model_bad++; else model_good++;
            end
         end
         prev_stall = pkt_valid && !pkt_ready;
         prev_word  = {pkt_data, pkt_sop, pkt_eop, pkt_err};
      end
   end

   task automatic add_exp(input logic [7:0] d, input logic s, input logic eo, input logic er, input logic ab);
      item_t it;
      it.data = d; it.sop = s; it.eop = eo; it.err = er; it.abort = ab;
      exp_q.push_back(it);
   endtask

   task automatic push_byte(input logic [7:0] b);
      @(posedge clk); #2;
      rtr_q.push_back(b);
   endtask

   // One packet: header {len,port}, payload (1..len or random), parity.
   task automatic send_pkt(input int len, input int port, input bit incr, input bit bad, input int max_gap);
      logic [7:0] b[$];
      logic [7:0] acc;
      int         n;
      b.push_back({len[5:0], port[1:0]});
      for (int i = 0; i < len; i++) b.push_back(incr ? 8'(i + 1) : 8'($urandom));
      acc = 8'h00;
      foreach (b[i]) acc ^= b[i];
      b.push_back(bad ? (acc ^ 8'h01) : acc);
      n = b.size();
      for (int i = 0; i < n; i++) add_exp(b[i], i == 0, i == n - 1, (i == n - 1) && bad, 1'b0);
      for (int i = 0; i < n; i++) begin
         if (max_gap > 0 && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, max_gap)) @(posedge clk);
         push_byte(b[i]);
      end
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || rtr_q.size() != 0) && n < budget) begin
         @(posedge clk);
         n++;
      end
      chk("drain_left", exp_q.size(), 0);
      repeat (3) @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rtr_q.delete();
      exp_q.delete();
      model_good = 0;
      model_bad  = 0;
      reset = 1'b1;
      @(posedge clk); #2;
      reset = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish by 500000");
      $fatal(1, "bench timeout");
   end

   initial begin
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
      // reset state
      chk("rst_valid", {31'd0, pkt_valid}, 0);
      chk("rst_busy", {31'd0, busy_rx}, 0);
      chk("rst_read", {31'd0, read_enb}, 0);
      chk("rst_tags", {29'd0, pkt_sop, pkt_eop, pkt_err}, 0);
      chk("rst_data", {24'd0, pkt_data}, 0);

      // 1: good len-8 packet
      ready_mode = 0;
      send_pkt(8, 0, 1'b1, 1'b0, 0);
      wait_drain(200);
      chk("t1_len", last_pkt_len, 10);
      chk("t1_eop_data", last_eop_data, 32'h28);
      chk("t1_eop_err", last_eop_err, 0);
`ifdef PORT_RX_STATS_EN
      chk("t1_pkt_count", {16'd0, pkt_count}, 1);
`endif

      // 2: same packet, wrong parity
      send_pkt(8, 0, 1'b1, 1'b1, 0);
      wait_drain(200);
      chk("t2_eop_data", last_eop_data, 32'h29);
      chk("t2_eop_err", last_eop_err, 1);
`ifdef PORT_RX_STATS_EN
      chk("t2_err_count", {16'd0, err_count}, 1);
`endif

      // 3: zero-length packet
      send_pkt(0, 1, 1'b1, 1'b0, 0);
      wait_drain(200);
      chk("t3_len", last_pkt_len, 2);
      chk("t3_eop_data", last_eop_data, 32'h01);
      chk("t3_eop_err", last_eop_err, 0);

      // 4: back-pressure pattern 1-0-0-1
      ready_mode = 2;
      send_pkt(8, 0, 1'b1, 1'b0, 0);
      wait_drain(400);
      chk("t4_len", last_pkt_len, 10);
      chk("t4_eop_err", last_eop_err, 0);
      chk("t4_busy", {31'd0, busy_rx}, 0);

      // 5: stall mid-packet -> abort, then a clean packet
      ready_mode = 0;
      add_exp(8'h20, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 3; i++) add_exp(8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      add_exp(8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
      push_byte(8'h20);
      for (int i = 1; i <= 3; i++) push_byte(8'(i));
      repeat (10) @(posedge clk);
      #2;
      chk("t5_busy_stall", {31'd0, busy_rx}, 1);
      repeat (35) @(posedge clk);
      #2;
      chk("t5_abort_seen", exp_q.size(), 0);
      chk("t5_busy_after", {31'd0, busy_rx}, 0);
      chk("t5_abort_len", last_pkt_len, 5);
      send_pkt(5, 3, 1'b0, 1'b0, 0);
      wait_drain(200);
      chk("t5_next_len", last_pkt_len, 7);
      chk("t5_next_err", last_eop_err, 0);

      // 6: reset mid-payload, then header 0x22 packet
      add_exp(8'h20, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 4; i++) add_exp(8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      push_byte(8'h20);
      for (int i = 1; i <= 4; i++) push_byte(8'(i));
      do_reset();
      chk("t6_read", {31'd0, read_enb}, 0);
      chk("t6_valid", {31'd0, pkt_valid}, 0);
      chk("t6_busy", {31'd0, busy_rx}, 0);
`ifdef PORT_RX_STATS_EN
      chk("t6_counts", {pkt_count, err_count}, 0);
`endif
      send_pkt(8, 2, 1'b1, 1'b0, 0);
      wait_drain(200);
      chk("t6_len", last_pkt_len, 10);
      chk("t6_eop_err", last_eop_err, 0);

      // randomized packets with random sink back-pressure and router gaps
      ready_mode = 1;
      for (int p = 0; p < 25; p++) begin
         send_pkt(($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 12),
                  $urandom_range(0, 3), 1'b0, ($urandom_range(0, 3) == 0), 4);
      end
      wait_drain(8000);
      chk("rand_busy_end", {31'd0, busy_rx}, 0);
      chk("rand_valid_end", {31'd0, pkt_valid}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
